// File: rtl/carregador_memoria.sv
// Boot loader: takes a length-prefixed byte stream, packs big-endian 32-bit words
// and writes them to consecutive memory addresses starting at BASE.
module carregador_memoria #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 600,
  parameter int BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [31:0]       dado,
  output logic [ADDR_W-1:0] endereco,
  output logic              write,
  output logic              ocupado,
  output logic              concluido,
  output logic              erro
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE
  } estado_t;

  localparam logic [31:0] LIMITE = 32'(DEPTH - BASE);

  estado_t           estado, prox;
  logic [15:0]       len;
  logic [15:0]       cont_pal;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        cont_byte;
  logic [23:0]       montagem;
  logic [15:0]       n_lo;

  // Handshake: a byte moves on a rising edge with byte_valid && byte_ready;
  // byte_ready depends on state only, never combinationally on byte_valid.
  assign n_lo = {len[15:8], byte_in};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= S_IDLE;
    else       estado <= prox;
  end

  always_comb begin
    prox       = estado;
    byte_ready = 1'b0;
    write      = 1'b0;
    ocupado    = 1'b0;
    concluido  = 1'b0;
    unique case (estado)
      S_IDLE: begin
        if (start) prox = S_LEN_HI;
      end
      S_LEN_HI: begin
        ocupado    = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) prox = S_LEN_LO;
      end
      S_LEN_LO: begin
        ocupado    = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (n_lo == 16'd0)                prox = S_DONE;
          else if ({16'd0, n_lo} > LIMITE)  prox = S_IDLE;
          else                              prox = S_DATA;
        end
      end
      S_DATA: begin
        ocupado    = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid && cont_byte == 2'd3) prox = S_WRITE;
      end
      S_WRITE: begin
        ocupado = 1'b1;
        write   = 1'b1;
        if (cont_pal + 16'd1 == len) prox = S_DONE;
        else                         prox = S_DATA;
      end
      S_DONE: begin
        concluido = 1'b1;
        prox      = S_IDLE;
      end
      default: prox = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len       <= '0;
      cont_pal  <= '0;
      addr      <= '0;
      cont_byte <= '0;
      montagem  <= '0;
      dado      <= '0;
      endereco  <= '0;
      erro      <= 1'b0;
    end else begin
      unique case (estado)
        S_IDLE: begin
          if (start) begin
            erro      <= 1'b0;
            cont_pal  <= '0;
            cont_byte <= '0;
            addr      <= ADDR_W'(BASE);
          end
        end
        S_LEN_HI: begin
          if (byte_valid) len <= {byte_in, 8'h00};
        end
        S_LEN_LO: begin
          if (byte_valid) begin
            len <= n_lo;
            if (n_lo != 16'd0 && {16'd0, n_lo} > LIMITE) erro <= 1'b1;
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            cont_byte <= cont_byte + 2'd1;
            montagem  <= {montagem[15:0], byte_in};
            // Latch the word and its address so they stay stable through WRITE and after.
            if (cont_byte == 2'd3) begin
              dado     <= {montagem, byte_in};
              endereco <= addr;
            end
          end
        end
        S_WRITE: begin
          addr      <= addr + ADDR_W'(1);
          cont_pal  <= cont_pal + 16'd1;
          cont_byte <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_memoria.sv
// Bench for carregador_memoria: random frames against a word-list reference model
// and a scoreboard of expected (address, word) writes.
module tb_carregador_memoria;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 600;
  localparam int BASE   = 0;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [31:0]       dado;
  logic [ADDR_W-1:0] endereco;
  logic              write;
  logic              ocupado;
  logic              concluido;
  logic              erro;

  carregador_memoria #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .dado(dado),
    .endereco(endereco), .write(write), .ocupado(ocupado),
    .concluido(concluido), .erro(erro)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        words[$];
  int                 write_cnt = 0;
  int                 conc_cnt  = 0;
  int                 conc_cyc  = 0;
  logic [ADDR_W-1:0]  last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // scoreboard: every write pulse must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset) begin
      if (write) begin
        write_cnt++;
        last_addr = endereco;
        if (exp_q.size() > 0) chk("write_word", {endereco, dado}, exp_q.pop_front());
      end
      if (concluido) begin
        conc_cnt++;
        conc_cyc = cyc;
      end
    end
  end

  // driver tasks (called and returning on a negedge)
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    int g;
    guard = 0;
    g = gap;
    byte_valid = 1'b0;
    while (g > 0 && guard < 100) begin
      if (byte_ready) g--;
      guard++;
      @(negedge clock);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 100) begin
      guard++;
      @(negedge clock);
    end
    chk("byte_accept", byte_ready, 1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  // mode 0: gapless, 1: 3-cycle stall before the 3rd byte of each word, 2: random stalls
  task automatic load(input int n, input int mode, input bit start_mid);
    int s, gaps, g, wc0, cc0, guard;
    logic [31:0] w;
    bit ok;
    gaps = 0;
    wc0  = write_cnt;
    cc0  = conc_cnt;
    ok   = (n <= DEPTH - BASE);
    exp_q.delete();
    start = 1'b1;
    s = cyc;
    @(negedge clock);
    start = 1'b0;
    chk("ocupado_rise", ocupado, 1);
    chk("erro_cleared_on_start", erro, 0);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
    if (!ok) begin
      chk("erro_set", erro, 1);
      chk("erro_ocupado_low", ocupado, 0);
      repeat (3) @(negedge clock);
      chk("erro_sticky", erro, 1);
      chk("erro_no_write", 64'(write_cnt - wc0), 0);
      chk("erro_no_done", 64'(conc_cnt - cc0), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = (words.size() > 0) ? words.pop_front() : $urandom;
      exp_q.push_back({ADDR_W'(BASE + i), w});
      for (int j = 0; j < 4; j++) begin
        g = (mode == 1 && j == 2) ? 3 : (mode == 2) ? $urandom_range(0, 2) : 0;
        gaps += g;
        if (start_mid && i == n / 2 && j == 0) start = 1'b1;
        send_byte(w[31 - 8*j -: 8], g);
        start = 1'b0;
      end
    end
    guard = 0;
    while (conc_cnt == cc0 && guard < 20) begin
      guard++;
      @(negedge clock);
    end
    chk("done_pulse", 64'(conc_cnt - cc0), 1);
    // inclusive cycle count, start cycle through concluido cycle
    chk("latency", 64'(conc_cyc - s + 1), 64'(1 + 2 + 5*n + 1 + gaps));
    @(negedge clock);
    chk("done_one_cycle", concluido, 0);
    chk("ocupado_fall", ocupado, 0);
    chk("write_count", 64'(write_cnt - wc0), 64'(n));
    chk("exp_drained", 64'(exp_q.size()), 0);
    chk("erro_clear", erro, 0);
  endtask

  initial begin
    int wc0;
    do_reset();
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_dado", dado, 0);
    chk("rst_endereco", endereco, 0);
    chk("rst_write", write, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_concluido", concluido, 0);
    chk("rst_erro", erro, 0);

    // reset in the middle of word 0
    wc0 = write_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    reset = 1'b1;
    #1;
    chk("midrst_byte_ready", byte_ready, 0);
    chk("midrst_dado", dado, 0);
    chk("midrst_endereco", endereco, 0);
    chk("midrst_write", write, 0);
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_concluido", concluido, 0);
    chk("midrst_erro", erro, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("midrst_no_write", 64'(write_cnt - wc0), 0);
    load(1, 0, 0);

    words.push_back(32'h04000154); words.push_back(32'h54000002);
    load(2, 0, 0);
    words.push_back(32'h04000154); words.push_back(32'h54000002);
    load(2, 1, 0);
    load(0, 0, 0);
    load(601, 0, 0);
    load(1, 0, 0);
    load(65535, 0, 0);
    load(3, 2, 0);
    repeat (6) load($urandom_range(1, 8), 2, 0);
    load(600, 0, 1);
    chk("last_addr", last_addr, 64'(DEPTH - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/carregador_memoria.md
# carregador_memoria

Boot loader that sits directly upstream of the processor's instruction/data memory and drives its write port (`dado`, `endereco`, `write`). It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive memory addresses starting at `BASE`. The processor is held off (`ocupado`) until the image is loaded. A one-cycle `concluido` pulse or a sticky `erro` flag reports the outcome.

## Interface
- `ADDR_W`, 10: width of the memory address bus.
- `DEPTH`, 600: number of memory words; the highest legal address is `DEPTH-1`.
- `BASE`, 0: address that receives the first loaded word.

Ports (clock and reset first):
- `clock` in 1: single clock; memory `wclk` is tied to the same net.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin a load; sampled only in IDLE.
- `byte_in` in 8: stream byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `dado` out 32: word to memory.
- `endereco` out ADDR_W: memory address.
- `write` out 1: memory write enable, one-cycle pulse per word.
- `ocupado` out 1: high from acceptance of `start` until return to IDLE.
- `concluido` out 1: one-cycle pulse on successful completion.
- `erro` out 1: length rejected; sticky until the next accepted `start` or `reset`.

## Operation
- A byte transfers on a rising edge where `byte_valid && byte_ready`. Bytes presented while `byte_ready` is low are not consumed.
- Frame format:
  - Length N: 16-bit, big-endian, counted in words.
  - Data: N×4 bytes, each word big-endian (first byte goes to `dado[31:24]`).
- States:
  - **IDLE**: `byte_ready`=0. `start`=1 → LEN_HI; set `ocupado`, clear `erro`, load word counter=0 and address=BASE.
  - **LEN_HI**: `byte_ready`=1. On a byte, capture N[15:8] → LEN_LO.
  - **LEN_LO**: `byte_ready`=1. On a byte, form N:
    - N=0 → DONE.
    - N > DEPTH−BASE → set `erro`, go to IDLE with no writes.
    - Otherwise → DATA.
  - **DATA**: `byte_ready`=1. Shift each byte into the assembly register and count bytes 0..3. On the 4th byte → WRITE.
  - **WRITE**: `byte_ready`=0. `write`=1 for exactly this cycle, with `dado`=assembled word and `endereco`=current address. Then increment the address and word counter. If the counter reaches N → DONE, else → DATA with byte count 0.
  - **DONE**: `concluido`=1 for one cycle, `ocupado`=0 → IDLE.
- Widths:
  - Length register and word counter are 16-bit.
  - Address register is ADDR_W bits. The range check in LEN_LO guarantees the address never exceeds DEPTH−1 and never wraps.
- `dado` and `endereco` hold their last values outside WRITE. `write` is low in every state except WRITE.
- `start` outside IDLE is ignored; it neither restarts nor aborts a load.
- `reset` at any time has immediate effect:
  - State → IDLE.
  - All outputs → 0, including `erro`.
  - Partial word and counters are discarded.
  - Words already written stay in memory.

## Timing
- Reset values: `byte_ready`=0, `dado`=0, `endereco`=0, `write`=0, `ocupado`=0, `concluido`=0, `erro`=0.
- `ocupado` rises in the cycle after the `start` edge.
- Per word: 4 accept cycles plus 1 WRITE cycle, so a gapless stream gives 5 cycles per word.
- `write` rises in the cycle after the 4th byte edge. Memory captures on the following rising edge.
- Total load time with a gapless stream: 1 + 2 + 5N + 1 cycles from `start` to `concluido`.
- Stalls (`byte_valid`=0) extend any accept state indefinitely with no timeout.
- `erro` rises in the cycle after the LEN_LO byte edge; `ocupado` falls in the same cycle.

## Test plan
- Reset mid-DATA after 2 bytes of word 0 → all outputs 0, no `write` pulse. A new `start` then loads cleanly from BASE.
- `start`, stream 00 02 | 04 00 01 54 | 54 00 00 02 gapless → `write` pulses carry 0x04000154 at address 0, then 0x54000002 at address 1. `concluido` pulses exactly 14 cycles after `start` (1 + 2 + 5×2 + 1).
- Same frame with `byte_valid` dropped for 3 cycles in the middle of each word → identical writes, with `concluido` delayed by 6 cycles.
- Length 00 00 → no `write`, `concluido` pulses 4 cycles after `start`.
- Length 0x0259 (601) with BASE=0 → `erro`=1, no `write`, `ocupado`=0. The next `start` clears `erro`.
- Boundary load: length 0x0258 (600) → last `write` goes to address 599 and `concluido` pulses. A `start` asserted mid-load has no effect.
